// File: rtl/id_arb_pkg.sv
// Shared types for the decode-stage thread arbiter.
// Tid width covers the largest supported thread count (8).
package id_arb_pkg;

  localparam int unsigned MaxThreads = 8;
  localparam int unsigned MaxTidW    = $clog2(MaxThreads);

  typedef logic [MaxTidW-1:0] tid_t;

  // Control half of the decoder-facing register; the
  // payload width is a module parameter, so it sits beside it.
  typedef struct packed {
    logic valid;
    tid_t tid;
  } out_reg_t;

  function automatic int unsigned rr_next(
    input int unsigned last,
    input int unsigned step,
    input int unsigned n
  );
    return (last + step) % n;
  endfunction

endpackage

// File: rtl/id_thread_arbiter_if.sv
// Fetch-to-decode handshake bundle for the thread arbiter.
// Macro ID_ARB_PERF_CNT_EN adds the per-thread grant counters.
interface id_thread_arbiter_if #(
  parameter int unsigned NrThreads  = 2,
  parameter int unsigned EntryWidth = 64
);
  import id_arb_pkg::*;

  localparam int unsigned TW = $clog2(NrThreads);

  logic [NrThreads-1:0]                 flush_i;
  logic [NrThreads-1:0]                 fetch_valid_i;
  logic [NrThreads-1:0][EntryWidth-1:0] fetch_entry_i;
  logic [NrThreads-1:0]                 fetch_ready_o;
  logic                                 dec_valid_o;
  logic [EntryWidth-1:0]                dec_entry_o;
  logic [TW-1:0]                        dec_tid_o;
  logic                                 dec_ack_i;
`ifdef ID_ARB_PERF_CNT_EN
  logic [NrThreads-1:0][31:0]           grant_cnt_o;
`endif

  modport master (
    output flush_i,
    output fetch_valid_i,
    output fetch_entry_i,
    output dec_ack_i,
    input  fetch_ready_o,
    input  dec_valid_o,
    input  dec_entry_o,
`ifdef ID_ARB_PERF_CNT_EN
    input  grant_cnt_o,
`endif
    input  dec_tid_o
  );

  modport slave (
    input  flush_i,
    input  fetch_valid_i,
    input  fetch_entry_i,
    input  dec_ack_i,
    output fetch_ready_o,
    output dec_valid_o,
    output dec_entry_o,
`ifdef ID_ARB_PERF_CNT_EN
    output grant_cnt_o,
`endif
    output dec_tid_o
  );

endinterface

// File: rtl/id_thread_arbiter_rr_select.sv
// Round-robin picker: first request strictly after i_last,
// wrapping to 0. Purely combinational.
module rr_select
  import id_arb_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // Walk the ring starting one past the last winner.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!o_any &&
          i_req[W'(rr_next(32'(i_last), k, N))]) begin
        o_idx = W'(rr_next(32'(i_last), k, N));
        o_gnt[o_idx] = 1'b1;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_thread_arbiter.sv
// Decode-stage thread arbiter with one registered output slot.
// Macro ID_ARB_PERF_CNT_EN adds grant_cnt_o counters.
module id_thread_arbiter
  import id_arb_pkg::*;
#(
  parameter int unsigned NrThreads  = 2,
  parameter int unsigned EntryWidth = 64
) (
  input logic                clk_i,
  input logic                rst_ni,
  id_thread_arbiter_if.slave bus
);

  localparam int unsigned TW = $clog2(NrThreads);

  out_reg_t              r_out;
  logic [EntryWidth-1:0] r_entry;
  logic [TW-1:0]         r_last;

  logic                 w_free;
  logic                 w_flush_held;
  logic [NrThreads-1:0] w_req;
  logic [NrThreads-1:0] w_gnt;
  logic [NrThreads-1:0] w_one;
  logic [TW-1:0]        w_idx;
  logic                 w_any;

  assign w_one  = NrThreads'(1);
  assign w_free = !r_out.valid || bus.dec_ack_i;

  // Flush aimed at the thread whose entry is currently held.
  assign w_flush_held =
    |(bus.flush_i & (w_one << r_out.tid));

  // Grants only into a free slot, never during reset.
  assign w_req = bus.fetch_valid_i
               & ~bus.flush_i
               & {NrThreads{w_free & rst_ni}};

  rr_select #(
    .N (NrThreads),
    .W (TW)
  ) u_rr (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign bus.fetch_ready_o = w_gnt;
  assign bus.dec_valid_o   = r_out.valid;
  assign bus.dec_entry_o   = r_entry;
  assign bus.dec_tid_o     = r_out.tid[TW-1:0];

  // Output slot: load on grant, drop on ack or held flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out   <= '0;
      r_entry <= '0;
      r_last  <= TW'(NrThreads - 1);
    end else if (w_any) begin
      r_out.valid <= 1'b1;
      r_out.tid   <= tid_t'(w_idx);
      r_entry     <= bus.fetch_entry_i[w_idx];
      r_last      <= w_idx;
    end else if (r_out.valid &&
                 (bus.dec_ack_i || w_flush_held)) begin
      r_out.valid <= 1'b0;
    end
  end

`ifdef ID_ARB_PERF_CNT_EN
  logic [NrThreads-1:0][31:0] r_cnt;

  // Per-thread grant counters, free-running wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      for (int unsigned t = 0; t < NrThreads; t++) begin
        if (w_gnt[t]) r_cnt[t] <= r_cnt[t] + 32'd1;
      end
    end
  end

  assign bus.grant_cnt_o = r_cnt;
`endif

endmodule

// File: tb/tb_id_thread_arbiter.sv
// Bench for id_thread_arbiter: model-based compare plus
// directed literal checks on 2- and 4-thread instances.
module tb_id_thread_arbiter;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;

  id_thread_arbiter_if #(.NrThreads(2), .EntryWidth(64)) bus_a ();
  id_thread_arbiter_if #(.NrThreads(4), .EntryWidth(16)) bus_b ();

  id_thread_arbiter #(.NrThreads(2), .EntryWidth(64)) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_a)
  );

  id_thread_arbiter #(.NrThreads(4), .EntryWidth(16)) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model of the 2-thread instance
  logic        m_valid;
  logic [63:0] m_entry;
  int          m_tid;
  int          m_last;

  function automatic int pick();
    logic free_;
    int   c;
    free_ = !m_valid || bus_a.dec_ack_i;
    if (!free_ || !rst_n) return -1;
    for (int k = 1; k <= 2; k++) begin
      c = (m_last + k) % 2;
      if (bus_a.fetch_valid_i[c] && !bus_a.flush_i[c])
        return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_entry <= 64'd0;
      m_tid   <= 0;
      m_last  <= 1;
    end else if (pick() >= 0) begin
      m_valid <= 1'b1;
      m_entry <= bus_a.fetch_entry_i[pick()];
      m_tid   <= pick();
      m_last  <= pick();
    end else if (m_valid &&
                 (bus_a.dec_ack_i || bus_a.flush_i[m_tid])) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_ready", 64'(bus_a.fetch_ready_o),
            (pick() >= 0) ? (64'd1 << pick()) : 64'd0);
      check("m_valid", 64'(bus_a.dec_valid_o), 64'(m_valid));
      check("m_tid", 64'(bus_a.dec_tid_o), 64'(m_tid));
      check("m_entry", bus_a.dec_entry_o, m_entry);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus_a.flush_i       = 2'b00;
    bus_a.fetch_valid_i = 2'b11;
    bus_a.fetch_entry_i[0] = 64'hA0;
    bus_a.fetch_entry_i[1] = 64'hB1;
    bus_a.dec_ack_i     = 1'b1;
    bus_b.flush_i       = 4'b0000;
    bus_b.fetch_valid_i = 4'b1010;
    bus_b.fetch_entry_i = '0;
    bus_b.dec_ack_i     = 1'b1;

    #2;
    check("rst_valid", 64'(bus_a.dec_valid_o), 64'd0);
    check("rst_entry", bus_a.dec_entry_o, 64'd0);
    check("rst_tid", 64'(bus_a.dec_tid_o), 64'd0);
    check("rst_ready_a", 64'(bus_a.fetch_ready_o), 64'd0);
    check("rst_ready_b", 64'(bus_b.fetch_ready_o), 64'd0);
    repeat (2) next();

    // Alternating grants with constant ack
    rst_n = 1'b1;
    #2;
    check("rr0_ready", 64'(bus_a.fetch_ready_o), 64'h1);
    check("rr0_valid", 64'(bus_a.dec_valid_o), 64'd0);
    check("b0_ready", 64'(bus_b.fetch_ready_o), 64'h2);
    next(); #2;
    check("rr1_ready", 64'(bus_a.fetch_ready_o), 64'h2);
    check("rr1_tid", 64'(bus_a.dec_tid_o), 64'd0);
    check("rr1_entry", bus_a.dec_entry_o, 64'hA0);
    check("b1_ready", 64'(bus_b.fetch_ready_o), 64'h8);
    check("b1_tid", 64'(bus_b.dec_tid_o), 64'd1);
    next(); #2;
    check("rr2_ready", 64'(bus_a.fetch_ready_o), 64'h1);
    check("rr2_tid", 64'(bus_a.dec_tid_o), 64'd1);
    check("rr2_entry", bus_a.dec_entry_o, 64'hB1);
    next(); #2;
    check("rr3_ready", 64'(bus_a.fetch_ready_o), 64'h2);
    check("rr3_tid", 64'(bus_a.dec_tid_o), 64'd0);

    // Stall with thread 1 held
    for (int i = 0; i < 5; i++) begin
      next();
      bus_a.dec_ack_i = 1'b0;
      #2;
      check("stall_ready", 64'(bus_a.fetch_ready_o), 64'd0);
      check("stall_entry", bus_a.dec_entry_o, 64'hB1);
      check("stall_tid", 64'(bus_a.dec_tid_o), 64'd1);
      check("stall_valid", 64'(bus_a.dec_valid_o), 64'd1);
    end

    // Flush of held thread 0 with nothing else to grant
    next();
    bus_a.dec_ack_i = 1'b1;
    bus_a.fetch_valid_i = 2'b01;
    #2;
    check("f0_ready", 64'(bus_a.fetch_ready_o), 64'h1);
    next();
    bus_a.dec_ack_i = 1'b0;
    bus_a.flush_i = 2'b01;
    #2;
    check("f1_ready", 64'(bus_a.fetch_ready_o), 64'd0);
    check("f1_tid", 64'(bus_a.dec_tid_o), 64'd0);
    next();
    bus_a.flush_i = 2'b00;
    bus_a.fetch_valid_i = 2'b00;
    #2;
    check("f2_valid", 64'(bus_a.dec_valid_o), 64'd0);
    check("f2_ready", 64'(bus_a.fetch_ready_o), 64'd0);

    // Flush of held thread 0 overwritten by thread 1 grant
    next();
    bus_a.fetch_valid_i = 2'b01;
    #2;
    check("o0_ready", 64'(bus_a.fetch_ready_o), 64'h1);
    next();
    bus_a.flush_i = 2'b01;
    bus_a.fetch_valid_i = 2'b11;
    bus_a.fetch_entry_i[1] = 64'hABCD;
    bus_a.dec_ack_i = 1'b1;
    #2;
    check("o1_ready", 64'(bus_a.fetch_ready_o), 64'h2);
    next();
    bus_a.flush_i = 2'b00;
    bus_a.dec_ack_i = 1'b0;
    bus_a.fetch_valid_i = 2'b11;
    #2;
    check("o2_valid", 64'(bus_a.dec_valid_o), 64'd1);
    check("o2_tid", 64'(bus_a.dec_tid_o), 64'd1);
    check("o2_entry", bus_a.dec_entry_o, 64'hABCD);

    // Reset asserted while an entry is held
    #1;
    rst_n = 1'b0;
    #1;
    check("mr_valid", 64'(bus_a.dec_valid_o), 64'd0);
    check("mr_ready", 64'(bus_a.fetch_ready_o), 64'd0);
    check("mr_entry", bus_a.dec_entry_o, 64'd0);
    next();
    rst_n = 1'b1;

    // Mixed traffic checked by the model
    for (int i = 0; i < 80; i++) begin
      next();
      bus_a.fetch_valid_i = 2'($urandom);
      bus_a.flush_i = ($urandom_range(0, 3) == 0) ?
                      2'($urandom) : 2'b00;
      bus_a.dec_ack_i = 1'($urandom);
      bus_a.fetch_entry_i[0] = {$urandom, $urandom};
      bus_a.fetch_entry_i[1] = {$urandom, $urandom};
    end

`ifdef ID_ARB_PERF_CNT_EN
    next();
    bus_a.fetch_valid_i = 2'b00;
    bus_a.flush_i = 2'b00;
    bus_a.dec_ack_i = 1'b1;
    next();
    force dut_a.r_cnt = {32'd0, 32'hFFFF_FFFF};
    #1;
    release dut_a.r_cnt;
    bus_a.fetch_valid_i = 2'b01;
    #1;
    check("cnt_ready", 64'(bus_a.fetch_ready_o), 64'h1);
    check("cnt_pre", 64'(bus_a.grant_cnt_o[0]), 64'hFFFF_FFFF);
    next();
    bus_a.fetch_valid_i = 2'b00;
    #2;
    check("cnt_wrap", 64'(bus_a.grant_cnt_o[0]), 64'd0);
    check("cnt_t1", 64'(bus_a.grant_cnt_o[1]), 64'd0);
`endif

    next();
    #3;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
